// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage with a simple req/ack data bus master.
//
// Drives a single outstanding bus access per load/store instruction. It holds
// the pipeline via stall_out while the access is in flight, then presents the
// formatted load data and passes the writeback control on to MEM_WB.
//
// Parameters:
//   TIMEOUT          max BUSY cycles to wait for mem_ack (1..255)
//
// Configuration macro:
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses skip the
//                         bus and raise misalign_exc for one cycle; when not
//                         defined, low address bits are ignored (forced
//                         aligned) and misalign_exc is tied low.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ALUResult_in / WriteData_in  effective address / store data
//   WriteReg_in                  destination register
//   MemRead_in, MemWrite_in      load / store request (both set = store)
//   MemSize_in, MemSigned_in     00 byte, 01 half, 1x word; load sign-extend
//   RegWrite_in, MemtoReg_in     writeback control
//   mem_req/we/addr/wdata/be     bus request side (held stable while BUSY)
//   mem_rdata, mem_ack           bus response side
//   ReadData_out, ALUResult_out, WriteReg_out, RegWrite_out, MemtoReg_out
//                                to MEM_WB
//   stall_out                    pipeline hold request to the hazard unit
//   bus_err                      one-cycle flag: access timed out
//   misalign_exc                 one-cycle flag: misaligned access trapped
//   state_dbg                    current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: mem_req is held high from the first BUSY cycle until the cycle
// mem_ack is sampled high (or the timeout expires); address, data, byte
// enables and write enable are stable for that whole window. mem_ack seen in
// any other state is ignored.
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] ALUResult_in,
   input  logic [31:0] WriteData_in,
   input  logic [4:0]  WriteReg_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [1:0]  MemSize_in,
   input  logic        MemSigned_in,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] ReadData_out,
   output logic [31:0] ALUResult_out,
   output logic [4:0]  WriteReg_out,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic        stall_out,
   output logic        bus_err,
   output logic        misalign_exc,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Last BUSY cycle index; the counter starts at 0 in the first BUSY cycle,
   // so BUSY lasts exactly TIMEOUT cycles when no ack arrives.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic [1:0]  off_q;     // byte offset of the latched access
   logic [1:0]  size_q;
   logic        signed_q;
   logic        load_q;

   logic        access;
   logic        sz_byte;
   logic        sz_half;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic        misalign_c;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   assign access  = MemRead_in | MemWrite_in;
   assign sz_byte = (MemSize_in == 2'b00);
   assign sz_half = (MemSize_in == 2'b01);

   // Half uses only addr[1] and word ignores addr[1:0], so misaligned
   // requests fold onto the aligned lane when trapping is not enabled.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = WriteData_in;
      if (sz_byte) begin
         be_c    = 4'b0001 << ALUResult_in[1:0];
         wdata_c = {4{WriteData_in[7:0]}};
      end else if (sz_half) begin
         be_c    = 4'b0011 << {ALUResult_in[1], 1'b0};
         wdata_c = {2{WriteData_in[15:0]}};
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_c = (sz_half & ALUResult_in[0]) |
                       (~sz_byte & ~sz_half & (ALUResult_in[1:0] != 2'b00));
`else
   assign misalign_c = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Load data formatting: pick the lane, then sign/zero extend.
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b00:   fmt_load = {{24{sgn & b[7]}}, b};
         2'b01:   fmt_load = {{16{sgn & h[15]}}, h};
         default: fmt_load = rd;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Control FSM with registered bus outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         mem_be       <= 4'd0;
         rdata_q      <= 32'd0;
         off_q        <= 2'd0;
         size_q       <= 2'd0;
         signed_q     <= 1'b0;
         load_q       <= 1'b0;
         bus_err      <= 1'b0;
         misalign_exc <= 1'b0;
      end else begin
         // Both flags are single-cycle pulses that only live in DONE.
         bus_err      <= 1'b0;
         misalign_exc <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  if (misalign_c) begin
                     // Trapped: no bus traffic, straight to DONE.
                     state        <= DONE;
                     misalign_exc <= 1'b1;
                     rdata_q      <= 32'd0;
                  end else begin
                     state     <= BUSY;
                     cnt       <= 8'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= MemWrite_in;
                     mem_addr  <= {ALUResult_in[31:2], 2'b00};
                     mem_wdata <= wdata_c;
                     mem_be    <= be_c;
                     off_q     <= ALUResult_in[1:0];
                     size_q    <= MemSize_in;
                     signed_q  <= MemSigned_in;
                     // A simultaneous read+write is a store.
                     load_q    <= MemRead_in & ~MemWrite_in;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if (load_q) begin
                     rdata_q <= fmt_load(mem_rdata, off_q, size_q, signed_q);
                  end
               end else if (cnt == CNT_LAST) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  rdata_q <= 32'd0;
                  bus_err <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               // The instruction holding the stage now is evaluated in IDLE.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Combinational outputs
   // ---------------------------------------------------------------------------
   // Stall is raised in the IDLE cycle that accepts an access and throughout
   // BUSY; gated by reset so it reads 0 while reset is asserted.
   assign stall_out     = reset_n & (((state == IDLE) & access) | (state == BUSY));
   assign ReadData_out  = rdata_q;
   assign ALUResult_out = ALUResult_in;
   assign WriteReg_out  = WriteReg_in;
   assign MemtoReg_out  = MemtoReg_in;
   // Error flags are only ever high in DONE, so they suppress writeback there.
   assign RegWrite_out  = RegWrite_in & ~bus_err & ~misalign_exc;
   assign state_dbg     = state;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed bench for mem_stage (TIMEOUT = 4).
// Stimulus pushes expected bus requests and DONE-cycle results into queues;
// a negedge monitor pops and compares whenever the DUT shows a new request
// or enters DONE.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic        clk;
   logic        reset_n;
   logic [31:0] ALUResult_in;
   logic [31:0] WriteData_in;
   logic [4:0]  WriteReg_in;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic [1:0]  MemSize_in;
   logic        MemSigned_in;
   logic        RegWrite_in;
   logic        MemtoReg_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] ReadData_out;
   logic [31:0] ALUResult_out;
   logic [4:0]  WriteReg_out;
   logic        RegWrite_out;
   logic        MemtoReg_out;
   logic        stall_out;
   logic        bus_err;
   logic        misalign_exc;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // bus expectation: {addr, wdata, be, we}
   logic [68:0] bus_q[$];
   // done expectation: {check_rdata, rdata, bus_err, misalign_exc, regwrite}
   logic [35:0] done_q[$];
   logic        req_prev = 1'b0;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in),
      .WriteReg_in(WriteReg_in), .MemRead_in(MemRead_in),
      .MemWrite_in(MemWrite_in), .MemSize_in(MemSize_in),
      .MemSigned_in(MemSigned_in), .RegWrite_in(RegWrite_in),
      .MemtoReg_in(MemtoReg_in), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
      .WriteReg_out(WriteReg_out), .RegWrite_out(RegWrite_out),
      .MemtoReg_out(MemtoReg_out), .stall_out(stall_out),
      .bus_err(bus_err), .misalign_exc(misalign_exc), .state_dbg(state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Check helper
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      logic [68:0] eb;
      logic [35:0] ed;
      if (reset_n) begin
         if (mem_req && !req_prev) begin
            if (bus_q.size() == 0) begin
               check("bus_unexpected_req", 69'd1, 69'd0);
            end else begin
               eb = bus_q.pop_front();
               check("bus_addr",  69'(mem_addr),  69'(eb[68:37]));
               check("bus_wdata", 69'(mem_wdata), 69'(eb[36:5]));
               check("bus_be",    69'(mem_be),    69'(eb[4:1]));
               check("bus_we",    69'(mem_we),    69'(eb[0]));
            end
         end
         if (state_dbg == S_DONE) begin
            if (done_q.size() == 0) begin
               check("done_unexpected", 69'd1, 69'd0);
            end else begin
               ed = done_q.pop_front();
               if (ed[35]) check("done_rdata", 69'(ReadData_out), 69'(ed[34:3]));
               check("done_bus_err",  69'(bus_err),      69'(ed[2]));
               check("done_misalign", 69'(misalign_exc), 69'(ed[1]));
               check("done_regwrite", 69'(RegWrite_out), 69'(ed[0]));
               check("done_stall",    69'(stall_out),    69'd0);
            end
         end else begin
            check("flags_outside_done", 69'({bus_err, misalign_exc}), 69'd0);
         end
      end
      req_prev = mem_req;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic expect_bus(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic we);
      bus_q.push_back({a, wd, be, we});
   endtask

   task automatic expect_done(input logic chk, input logic [31:0] rd,
                              input logic berr, input logic mis, input logic rw);
      done_q.push_back({chk, rd, berr, mis, rw});
   endtask

   task automatic drive_nop();
      MemRead_in  = 1'b0;
      MemWrite_in = 1'b0;
      mem_ack     = 1'b0;
   endtask

   // ack_after: BUSY cycle (1-based) in which mem_ack is presented, 0 = never
   task automatic run_access(input string name, input logic [31:0] addr,
                             input logic [31:0] wd, input logic rd, input logic wr,
                             input logic [1:0] size, input logic sgn,
                             input logic rw, input logic [31:0] rdata,
                             input int ack_after, input int exp_stall);
      int  stalls = 0;
      int  busy   = 0;
      bit  done   = 0;
      @(posedge clk);
      #1;
      ALUResult_in = addr;
      WriteData_in = wd;
      MemRead_in   = rd;
      MemWrite_in  = wr;
      MemSize_in   = size;
      MemSigned_in = sgn;
      RegWrite_in  = rw;
      mem_rdata    = rdata;
      mem_ack      = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (state_dbg == S_DONE) begin
            done = 1;
            break;
         end
         if (stall_out) stalls++;
         if (state_dbg == S_BUSY) begin
            busy++;
            mem_ack = (ack_after != 0) && (busy == ack_after);
         end
      end
      if (!done) begin
         $display("FAIL %s_done_timeout: got no DONE expected DONE", name);
         n_fail++;
         n_checks++;
      end
      check({name, "_stall_cycles"}, 69'(stalls), 69'(exp_stall));
      #1;
      drive_nop();
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      reset_n      = 1'b0;
      ALUResult_in = 32'h0;
      WriteData_in = 32'h0;
      WriteReg_in  = 5'd0;
      MemSize_in   = 2'b10;
      MemSigned_in = 1'b0;
      RegWrite_in  = 1'b0;
      MemtoReg_in  = 1'b0;
      mem_rdata    = 32'h0;
      MemRead_in   = 1'b1;   // stall must still read 0 while in reset
      MemWrite_in  = 1'b0;
      mem_ack      = 1'b0;

      // Reset state
      #12;
      check("rst_state",   69'(state_dbg),    69'(S_IDLE));
      check("rst_req",     69'(mem_req),      69'd0);
      check("rst_we",      69'(mem_we),       69'd0);
      check("rst_addr",    69'(mem_addr),     69'd0);
      check("rst_wdata",   69'(mem_wdata),    69'd0);
      check("rst_be",      69'(mem_be),       69'd0);
      check("rst_rdata",   69'(ReadData_out), 69'd0);
      check("rst_bus_err", 69'(bus_err),      69'd0);
      check("rst_misalign",69'(misalign_exc), 69'd0);
      check("rst_stall",   69'(stall_out),    69'd0);
      drive_nop();
      @(negedge clk);
      reset_n = 1'b1;

      // Pass-through with no access
      ALUResult_in = 32'h1234_5678;
      WriteReg_in  = 5'd17;
      RegWrite_in  = 1'b1;
      MemtoReg_in  = 1'b1;
      @(negedge clk);
      check("pt_alu",      69'(ALUResult_out), 69'(32'h1234_5678));
      check("pt_wreg",     69'(WriteReg_out),  69'(5'd17));
      check("pt_regwrite", 69'(RegWrite_out),  69'd1);
      check("pt_memtoreg", 69'(MemtoReg_out),  69'd1);
      check("pt_stall",    69'(stall_out),     69'd0);
      check("pt_state",    69'(state_dbg),     69'(S_IDLE));
      MemtoReg_in = 1'b0;

      // LW 0x100, zero-wait ack
      expect_bus(32'h100, 32'h1111_2222, 4'b1111, 1'b0);
      expect_done(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      run_access("lw", 32'h100, 32'h1111_2222, 1, 0, 2'b10, 0, 1, 32'hDEAD_BEEF, 1, 2);

      // LB signed 0x103
      expect_bus(32'h100, 32'h0, 4'b1000, 1'b0);
      expect_done(1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
      run_access("lb", 32'h103, 32'h0, 1, 0, 2'b00, 1, 1, 32'h8012_3456, 1, 2);

      // LBU 0x103
      expect_bus(32'h100, 32'h0, 4'b1000, 1'b0);
      expect_done(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
      run_access("lbu", 32'h103, 32'h0, 1, 0, 2'b00, 0, 1, 32'h8012_3456, 1, 2);

      // SH 0x202, ack in third BUSY cycle
      expect_bus(32'h200, 32'hABCD_ABCD, 4'b1100, 1'b1);
      expect_done(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      run_access("sh", 32'h202, 32'h0000_ABCD, 0, 1, 2'b01, 0, 0, 32'h0, 3, 4);

      // LW timeout (TIMEOUT = 4): 1 IDLE + 4 BUSY stall cycles
      expect_bus(32'h300, 32'h0, 4'b1111, 1'b0);
      expect_done(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
      run_access("lw_to", 32'h300, 32'h0, 1, 0, 2'b10, 0, 1, 32'h5555_5555, 0, 5);

      // LHU 0x102, upper half, two-cycle wait
      expect_bus(32'h100, 32'h0, 4'b1100, 1'b0);
      expect_done(1'b1, 32'h0000_8765, 1'b0, 1'b0, 1'b1);
      run_access("lhu", 32'h102, 32'h0, 1, 0, 2'b01, 0, 1, 32'h8765_ABCD, 2, 3);

      // SB 0x001
      expect_bus(32'h0, 32'h5A5A_5A5A, 4'b0010, 1'b1);
      expect_done(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      run_access("sb", 32'h001, 32'h0000_005A, 0, 1, 2'b00, 0, 0, 32'h0, 1, 2);

      // Read and write both set: treated as a store
      expect_bus(32'h404, 32'hCAFE_F00D, 4'b1111, 1'b1);
      expect_done(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      run_access("rw_both", 32'h404, 32'hCAFE_F00D, 1, 1, 2'b10, 0, 0, 32'h0, 1, 2);

      // Size 11 treated as word
      expect_bus(32'h108, 32'h0, 4'b1111, 1'b0);
      expect_done(1'b1, 32'h0102_0304, 1'b0, 1'b0, 1'b1);
      run_access("lw_sz3", 32'h108, 32'h0, 1, 0, 2'b11, 0, 1, 32'h0102_0304, 1, 2);

      // LH signed 0x101: misaligned
`ifdef MEM_MISALIGN_TRAP_EN
      expect_done(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      run_access("lh_mis", 32'h101, 32'h0, 1, 0, 2'b01, 1, 1, 32'h1234_F678, 0, 1);
`else
      expect_bus(32'h100, 32'h0, 4'b0011, 1'b0);
      expect_done(1'b1, 32'hFFFF_F678, 1'b0, 1'b0, 1'b1);
      run_access("lh_mis", 32'h101, 32'h0, 1, 0, 2'b01, 1, 1, 32'h1234_F678, 1, 2);
`endif

      // Reset in the middle of BUSY; a late ack must be ignored
      @(posedge clk);
      #1;
      expect_bus(32'h500, 32'h0, 4'b1111, 1'b0);
      ALUResult_in = 32'h500;
      WriteData_in = 32'h0;
      MemSize_in   = 2'b10;
      MemRead_in   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mid_busy_state", 69'(state_dbg), 69'(S_BUSY));
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_mid_req",   69'(mem_req),   69'd0);
      check("rst_mid_state", 69'(state_dbg), 69'(S_IDLE));
      check("rst_mid_stall", 69'(stall_out), 69'd0);
      check("rst_mid_be",    69'(mem_be),    69'd0);
      MemRead_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("late_ack_req",   69'(mem_req),   69'd0);
         check("late_ack_state", 69'(state_dbg), 69'(S_IDLE));
      end
      mem_ack = 1'b0;

      repeat (3) @(negedge clk);
      check("bus_q_empty",  69'(bus_q.size()),  69'd0);
      check("done_q_empty", 69'(done_q.size()), 69'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum number of BUSY cycles to wait for mem_ack (1..255).
REQ-002 Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- ALUResult_in  in  32  effective address, or the ALU result for non-memory instructions.
- WriteData_in  in  32  store data.
- WriteReg_in  in  5  destination register.
- MemRead_in, MemWrite_in  in  1 each  load and store request.
- MemSize_in  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
- MemSigned_in  in  1  sign-extend loads when 1, zero-extend when 0.
- RegWrite_in, MemtoReg_in  in  1 each  writeback control.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned bus address.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  bus read data.
- mem_ack  in  1  bus completion.
- ReadData_out  out  32  formatted load data, to MEM_WB.
- ALUResult_out  out  32  to MEM_WB.
- WriteReg_out  out  5  to MEM_WB.
- RegWrite_out, MemtoReg_out  out  1 each  to MEM_WB.
- stall_out  out  1  pipeline stall request, to the hazard unit.
- bus_err  out  1  one-cycle timeout flag.
- misalign_exc  out  1  one-cycle misalignment flag.

Function
REQ-003 FSM states: IDLE, BUSY, DONE.
REQ-004 IDLE, MemRead_in|MemWrite_in=1:
- stall_out=1 combinationally.
- Latch address, data, be and we.
- Next state BUSY; the timeout counter clears.
REQ-005 IDLE, no access: stall_out=0; outputs pass through; stays IDLE.
REQ-006 BUSY:
- mem_req=1 and stall_out=1.
- mem_addr, mem_wdata, mem_be and mem_we stay stable from the latched values.
- Counter increments each cycle.
REQ-007 BUSY and mem_ack=1: capture formatted mem_rdata into rdata_q (loads only) and go to DONE; mem_req=0 in DONE.
REQ-008 BUSY, counter reaches TIMEOUT with no ack:
- Drop mem_req, rdata_q=0, go to DONE.
- bus_err=1 during DONE; RegWrite_out=0 during DONE.
REQ-009 DONE:
- stall_out=0 and ReadData_out=rdata_q.
- Next state IDLE unconditionally.
- An access in DONE is not restarted.
- The next instruction is evaluated in IDLE.
REQ-010 Minimum access: zero-wait ack gives stall_out high for 2 cycles (IDLE, BUSY) and release in DONE.
REQ-011 mem_addr = {addr[31:2],2'b00}.
REQ-012 mem_be:
- byte: 4'b0001<<addr[1:0].
- half: 4'b0011<<{addr[1],1'b0}.
- word: 4'b1111.
REQ-013 mem_wdata: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-014 Load formatting: select the lane by addr[1:0] or addr[1], then extend to 32 bits per MemSigned_in; word loads are unmodified.
REQ-015 ALUResult_out, WriteReg_out and MemtoReg_out follow their inputs combinationally in all states.
REQ-016 RegWrite_out follows RegWrite_in except where REQ-008 or REQ-020 forces it to 0.
REQ-017 A mem_ack outside BUSY is ignored.
REQ-018 MemRead_in and MemWrite_in both 1: treated as a store.

Reset
REQ-019 When reset_n=0, asynchronously:
- state=IDLE, counter=0.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- rdata_q=0, bus_err=0, misalign_exc=0, stall_out=0.
- An in-flight access is abandoned; no ack is awaited after reset release.

Configuration
REQ-020 Macro MEM_MISALIGN_TRAP_EN defined:
- Misaligned accesses are half with addr[0]=1, or word with addr[1:0]!=0.
- A misaligned access goes IDLE->DONE with no bus request; stall_out=1 for that one IDLE cycle.
- misalign_exc=1 and RegWrite_out=0 in DONE.
REQ-021 Macro undefined:
- Low address bits are forced aligned (half ignores addr[0]; word ignores addr[1:0]).
- misalign_exc is tied 0; the port still exists.

Verification
REQ-022 LW addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, stall 2 cycles, ReadData_out 0xDEADBEEF in DONE.
REQ-023 LB signed addr 0x103, rdata 0x80123456 -> be 1000, ReadData_out 0xFFFFFF80; LBU -> 0x00000080.
REQ-024 SH addr 0x202, wd 0x0000ABCD, ack after 3 cycles -> be 1100, wdata 0xABCDABCD, we=1, stall_out high 4 cycles.
REQ-025 LW with no ack, TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, bus_err=1 for one cycle, RegWrite_out=0, ReadData_out 0.
REQ-026 LH addr 0x101 -> with macro: no mem_req, misalign_exc=1 one cycle; without macro: mem_be 0011 and a normal access.
REQ-027 reset_n low mid-BUSY -> mem_req=0 and state=IDLE immediately; a late ack is ignored.
